// File: rtl/md_issue_queue_pkg.sv
// Shared definitions for the multiply/divide issue queue: op codes, FSM states, queue entry.
// The op codes match the ones decoded by the multiply/divide unit.
package md_issue_queue_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [OP_W-1:0] MD_NOP   = 4'h0;
  localparam logic [OP_W-1:0] MD_MULT  = 4'h1;
  localparam logic [OP_W-1:0] MD_MULTU = 4'h2;
  localparam logic [OP_W-1:0] MD_DIV   = 4'h3;
  localparam logic [OP_W-1:0] MD_DIVU  = 4'h4;
  localparam logic [OP_W-1:0] MD_MTHI  = 4'h5;
  localparam logic [OP_W-1:0] MD_MTLO  = 4'h6;
  localparam logic [OP_W-1:0] MD_MFHI  = 4'h7;
  localparam logic [OP_W-1:0] MD_MFLO  = 4'h8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } md_state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } md_entry_t;

  // True for ops that occupy the unit; everything else commits in its issue cycle.
  function automatic logic op_starts_unit(input logic [OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_issue_queue_fifo.sv
// md_fifo: request storage for the issue queue with wrapping pointers and an occupancy count.
// flush and reset both empty the queue on the next edge; a push in a flush cycle is dropped.
module md_fifo
  import md_issue_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  md_entry_t        wr_data,
  output md_entry_t        rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  md_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign rd_data = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/md_issue_queue.sv
// md_issue_queue: queues mult/div/mthi/mtlo requests from E-stage and issues them in order.
// Optional macro MD_QUEUE_BYPASS_EN issues into an idle, empty queue in the same cycle.
module md_issue_queue
  import md_issue_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              md_start,
  output logic [OP_W-1:0]   md_op,
  output logic [DATA_W-1:0] md_a,
  output logic [DATA_W-1:0] md_b,
  input  logic              md_busy,
  input  logic              flush,
  output logic              hilo_stall,
  output logic [CNT_W-1:0]  count
);

  md_state_t state;
  md_entry_t req_entry;
  md_entry_t head;
  md_entry_t issue_entry;
  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  logic      bypass;
  logic      issue;
  logic      pending;

  assign req_entry = '{op: req_op, a: req_a, b: req_b};
  assign req_ready = !full;

`ifdef MD_QUEUE_BYPASS_EN
  assign bypass = (state == IDLE) && empty && !md_busy && req_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign push        = req_valid && req_ready && !bypass && !flush;
  assign pop         = (state == ISSUE) && !empty && !md_busy && !flush;
  assign issue       = pop || bypass;
  assign issue_entry = bypass ? req_entry : head;

  // Queue holds something after this edge (flush empties it regardless).
  assign pending = !flush && (push || (count > CNT_W'(pop)));

  md_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (req_entry),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Unit interface is quiet (NOP, zero operands) outside an issue cycle.
  always_comb begin
    md_start = 1'b0;
    md_op    = MD_NOP;
    md_a     = '0;
    md_b     = '0;
    if (issue) begin
      md_start = op_starts_unit(issue_entry.op);
      md_op    = issue_entry.op;
      md_a     = issue_entry.a;
      md_b     = issue_entry.b;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else if (issue && md_start) begin
      state <= WAIT;
    end else begin
      unique case (state)
        IDLE, ISSUE: state <= pending ? ISSUE : IDLE;
        WAIT:        if (!md_busy) state <= pending ? ISSUE : IDLE;
        default:     state <= IDLE;
      endcase
    end
  end

  assign hilo_stall = (count != '0) || md_busy || (state == ISSUE) || (state == WAIT);

endmodule

// File: tb/tb_md_issue_queue.sv
// Directed bench for md_issue_queue with a behavioural multiply/divide unit (5-cycle busy).
module tb_md_issue_queue;
  import md_issue_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              clk        = 1'b0;
  logic              reset      = 1'b0;
  logic              req_valid  = 1'b0;
  logic [OP_W-1:0]   req_op     = MD_NOP;
  logic [DATA_W-1:0] req_a      = '0;
  logic [DATA_W-1:0] req_b      = '0;
  logic              flush      = 1'b0;
  logic              busy_force = 1'b0;
  logic              req_ready;
  logic              md_start;
  logic [OP_W-1:0]   md_op;
  logic [DATA_W-1:0] md_a;
  logic [DATA_W-1:0] md_b;
  logic              md_busy;
  logic              hilo_stall;
  logic [CNT_W-1:0]  count;

  int          busy_cnt = 0;
  logic [31:0] hi       = '0;
  logic [31:0] lo       = '0;
  int          checks   = 0;
  int          errors   = 0;

  md_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .md_start   (md_start),
    .md_op      (md_op),
    .md_a       (md_a),
    .md_b       (md_b),
    .md_busy    (md_busy),
    .flush      (flush),
    .hilo_stall (hilo_stall),
    .count      (count)
  );

  always #5 clk = ~clk;

  assign md_busy = (busy_cnt != 0) || busy_force;

  function automatic logic [63:0] unit_result(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0]        ua;
    logic [63:0]        ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MD_MULT:  return sa * sb;
      MD_MULTU: return ua * ub;
      MD_DIV:   return (b == 0) ? 64'd0 : {32'(sa % sb), 32'(sa / sb)};
      MD_DIVU:  return (b == 0) ? 64'd0 : {32'(ua % ub), 32'(ua / ub)};
      default:  return 64'd0;
    endcase
  endfunction

  // Unit model: start launches a 5-cycle operation; mthi/mtlo write in their issue cycle.
  always @(posedge clk) begin
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (md_start) begin
      busy_cnt   <= 5;
      {hi, lo}   <= unit_result(md_op, md_a, md_b);
    end else if (md_op == MD_MTHI) begin
      hi <= md_a;
    end else if (md_op == MD_MTLO) begin
      lo <= md_a;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_stall_clear(input string tag, input int limit);
    int n = 0;
    while (hilo_stall !== 1'b0 && n < limit) begin
      cyc();
      n++;
    end
    check(tag, 32'(hilo_stall), 0);
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    req_valid = v;
    req_op    = op;
    req_a     = a;
    req_b     = b;
  endtask

  initial begin
    int n;
    // Reset
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_ready", 32'(req_ready), 1);
    check("rst_start", 32'(md_start), 0);
    check("rst_op", 32'(md_op), 32'(MD_NOP));
    check("rst_a", md_a, 0);
    check("rst_b", md_b, 0);
    check("rst_stall", 32'(hilo_stall), 0);

    // Single MULT -3 * 7
    cyc();
    drive(1'b1, MD_MULT, 32'hFFFF_FFFD, 32'd7);
    #1;
`ifdef MD_QUEUE_BYPASS_EN
    check("byp_start", 32'(md_start), 1);
    check("byp_op", 32'(md_op), 32'(MD_MULT));
    check("byp_a", md_a, 32'hFFFF_FFFD);
    cyc();
    drive(1'b0, MD_NOP, 0, 0);
    #1;
    check("byp_count", 32'(count), 0);
`else
    check("mult_nostart", 32'(md_start), 0);
    check("mult_ready", 32'(req_ready), 1);
    cyc();
    drive(1'b0, MD_NOP, 0, 0);
    #1;
    check("mult_start", 32'(md_start), 1);
    check("mult_op", 32'(md_op), 32'(MD_MULT));
    check("mult_a", md_a, 32'hFFFF_FFFD);
    check("mult_b", md_b, 32'd7);
    check("mult_count", 32'(count), 1);
    check("mult_stall", 32'(hilo_stall), 1);
    cyc();
`endif
    for (int i = 0; i < 5; i++) begin
      check("wait_busy", 32'(md_busy), 1);
      check("wait_start", 32'(md_start), 0);
      check("wait_op", 32'(md_op), 32'(MD_NOP));
      check("wait_stall", 32'(hilo_stall), 1);
      cyc();
    end
    check("wait_done_busy", 32'(md_busy), 0);
    check("wait_done_stall", 32'(hilo_stall), 1);
    cyc();
    check("idle_stall", 32'(hilo_stall), 0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);

    // DIVU 100/7 followed by MTHI 0x55
    cyc();
    busy_force = 1'b1;
    drive(1'b1, MD_DIVU, 32'd100, 32'd7);
    #1;
    check("divu_ready", 32'(req_ready), 1);
    cyc();
    busy_force = 1'b0;
    drive(1'b1, MD_MTHI, 32'h55, 32'd0);
    #1;
    check("divu_start", 32'(md_start), 1);
    check("divu_op", 32'(md_op), 32'(MD_DIVU));
    check("divu_a", md_a, 32'd100);
    check("divu_b", md_b, 32'd7);
    cyc();
    drive(1'b0, MD_NOP, 0, 0);
    #1;
    check("mthi_queued", 32'(count), 1);
    check("mthi_held", 32'(md_start), 0);
    n = 0;
    while (md_op !== MD_MTHI && n < 10) begin
      cyc();
      n++;
    end
    check("mthi_op", 32'(md_op), 32'(MD_MTHI));
    check("mthi_nostart", 32'(md_start), 0);
    check("mthi_a", md_a, 32'h55);
    check("mthi_busy", 32'(md_busy), 0);
    cyc();
    check("b2b_stall", 32'(hilo_stall), 0);
    check("b2b_hi", hi, 32'h55);
    check("b2b_lo", lo, 32'd14);

    // Fill the queue while the unit is busy
    cyc();
    busy_force = 1'b1;
    drive(1'b1, MD_MTLO, 32'd1, 32'd0);
    #1;
    check("fill_ready0", 32'(req_ready), 1);
    for (int i = 1; i < 4; i++) begin
      cyc();
      req_a = 32'(i + 1);
      #1;
      check("fill_count", 32'(count), 32'(i));
      check("fill_ready", 32'(req_ready), 1);
    end
    cyc();
    req_a = 32'd5;
    #1;
    check("full_count", 32'(count), 4);
    check("full_ready", 32'(req_ready), 0);
    cyc();
    check("full_hold_count", 32'(count), 4);
    check("full_hold_ready", 32'(req_ready), 0);
    check("full_hold_start", 32'(md_op), 32'(MD_NOP));
    cyc();
    busy_force = 1'b0;
    #1;
    check("drain1_op", 32'(md_op), 32'(MD_MTLO));
    check("drain1_a", md_a, 32'd1);
    check("drain1_ready", 32'(req_ready), 0);
    cyc();
    check("drain2_a", md_a, 32'd2);
    check("drain2_count", 32'(count), 3);
    check("drain2_ready", 32'(req_ready), 1);
    cyc();
    req_valid = 1'b0;
    #1;
    check("drain3_a", md_a, 32'd3);
    check("drain3_count", 32'(count), 3);
    cyc();
    check("drain4_a", md_a, 32'd4);
    check("drain4_count", 32'(count), 2);
    cyc();
    check("drain5_a", md_a, 32'd5);
    check("drain5_start", 32'(md_start), 0);
    cyc();
    check("drain_idle_count", 32'(count), 0);
    check("drain_idle_op", 32'(md_op), 32'(MD_NOP));
    check("drain_idle_stall", 32'(hilo_stall), 0);
    check("drain_lo", lo, 32'd5);

    // Flush with three queued and a MULTU in flight
    cyc();
    busy_force = 1'b1;
    drive(1'b1, MD_MULTU, 32'd6, 32'd7);
    cyc();
    busy_force = 1'b0;
    drive(1'b1, MD_MTHI, 32'hAA, 32'd0);
    #1;
    check("fl_start", 32'(md_start), 1);
    check("fl_op", 32'(md_op), 32'(MD_MULTU));
    cyc();
    drive(1'b1, MD_MTLO, 32'hBB, 32'd0);
    cyc();
    drive(1'b1, MD_MTHI, 32'hCC, 32'd0);
    cyc();
    flush = 1'b1;
    drive(1'b1, MD_MTLO, 32'hDD, 32'd0);
    #1;
    check("fl_pre_count", 32'(count), 3);
    check("fl_pre_start", 32'(md_start), 0);
    cyc();
    flush = 1'b0;
    req_valid = 1'b0;
    #1;
    check("fl_count", 32'(count), 0);
    check("fl_busy", 32'(md_busy), 1);
    check("fl_stall", 32'(hilo_stall), 1);
    wait_stall_clear("fl_stall_clear", 10);
    check("fl_busy_done", 32'(md_busy), 0);
    check("fl_hi", hi, 32'd0);
    check("fl_lo", lo, 32'd42);

    // Reset during WAIT with two queued
    cyc();
    busy_force = 1'b1;
    drive(1'b1, MD_MULT, 32'd2, 32'd3);
    cyc();
    busy_force = 1'b0;
    drive(1'b1, MD_MTLO, 32'h11, 32'd0);
    #1;
    check("rw_start", 32'(md_start), 1);
    cyc();
    drive(1'b1, MD_MTHI, 32'h22, 32'd0);
    cyc();
    req_valid = 1'b0;
    reset     = 1'b0;
    #1;
    check("rw_pre_count", 32'(count), 2);
    cyc();
    reset = 1'b1;
    #1;
    check("rw_count", 32'(count), 0);
    check("rw_start0", 32'(md_start), 0);
    check("rw_op", 32'(md_op), 32'(MD_NOP));
    check("rw_ready", 32'(req_ready), 1);
    check("rw_busy_stall", 32'(hilo_stall), 1);
    wait_stall_clear("rw_stall_clear", 10);
    check("rw_hi", hi, 32'd0);
    check("rw_lo", lo, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
